// File: rtl/memoria_resp.sv
// Single-port register memory with a request/acknowledge handshake and out-of-range error flag.
// Optional power-up clear sweep of every word is enabled by defining RAM_INIT_CLEAR_EN.
module memoria_resp #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              wren,
    input  logic [7:0]        address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef RAM_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;
    localparam state_t ST_RESET  = ST_CLEAR;
    localparam logic   BUSY_RST  = 1'b1;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;
    localparam state_t ST_RESET  = ST_IDLE;
    localparam logic   BUSY_RST  = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_out;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;
    logic                w_accept;
    logic                w_in_range;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_rd_data;
`ifdef RAM_INIT_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_cnt;
`endif

    // Upper address bits only qualify the range; they never fold onto lower words.
    assign w_in_range = ((address >> ADDR_W) == 8'd0);
    assign w_rd_data  = r_mem[address[ADDR_W-1:0]];

    assign out  = r_out;
    assign ack  = r_ack;
    assign err  = r_err;
    assign busy = r_busy;

    // Next-state decode, request acceptance and memory write port selection.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = address[ADDR_W-1:0];
        w_mem_wdata = data;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_mem_we    = wren & w_in_range;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef RAM_INIT_CLEAR_EN
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = {DATA_W{1'b0}};
                if (&r_clr_cnt) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access or sweep in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef RAM_INIT_CLEAR_EN
    // Clear sweep address counter, restarted from word 0 by every reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clr_cnt <= {ADDR_W{1'b0}};
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end
`endif

    // Storage array; the write is gated by resetn so nothing lands while reset is held.
    always_ff @(posedge clock) begin
        if (w_mem_we && resetn) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered response: result word, one-cycle ack/err pulse and busy flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_out  <= {DATA_W{1'b0}};
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= BUSY_RST;
        end else begin
            r_ack  <= w_accept;
            r_err  <= w_accept & ~w_in_range;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                if (!w_in_range) begin
                    r_out <= {DATA_W{1'b0}};
                end else if (wren) begin
                    r_out <= data;
                end else begin
                    r_out <= w_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_memoria_resp.sv
// Directed self-checking bench for memoria_resp; the clear-sweep scenario is built when RAM_INIT_CLEAR_EN is defined.
module tb_memoria_resp;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req;
    logic       wren;
    logic [7:0] address;
    logic [7:0] data;
    logic [7:0] out;
    logic       ack;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memoria_resp #(.ADDR_W(5), .DATA_W(8)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .req     (req),
        .wren    (wren),
        .address (address),
        .data    (data),
        .out     (out),
        .ack     (ack),
        .err     (err),
        .busy    (busy)
    );

    // One access: drive at a falling edge, capture the ACK-cycle outputs one cycle later, then let it return to IDLE.
    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] o_out, output logic o_ack,
                          output logic o_err, output logic o_busy);
        @(negedge clock);
        req = 1'b1; wren = w; address = a; data = d;
        @(negedge clock);
        o_out = out; o_ack = ack; o_err = err; o_busy = busy;
        req = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; wren = 1'b0; address = 8'd0; data = 8'd0;
        repeat (3) @(negedge clock);
        checks++;
        if ({out, ack, err} !== {8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: out=%h ack=%b err=%b, required 00 0 0", out, ack, err);
        end
`ifdef RAM_INIT_CLEAR_EN
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: busy=%b, required 1", busy);
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy=%b, required 0", busy);
        end
`endif
        resetn = 1'b1;
    endtask

`ifdef RAM_INIT_CLEAR_EN
    task automatic test_clear();
        logic [7:0] o; logic a, e, b;
        req = 1'b1; wren = 1'b1; address = 8'd31; data = 8'hFF;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clock);
            checks++;
            if (busy !== (i < 32) || ack !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle%0d: busy=%b ack=%b, required busy=%b ack=0", i, busy, ack, (i < 32));
            end
        end
        req = 1'b0;
        access(1'b0, 8'd31, 8'd0, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clear_read31: ack=%b err=%b out=%h, required 1 0 00", a, e, o);
        end
    endtask
`endif

    task automatic test_write_read();
        logic [7:0] o; logic a, e, b;
        access(1'b1, 8'd3, 8'd42, o, a, e, b);
        checks++;
        if ({a, e, b, o} !== {1'b1, 1'b0, 1'b1, 8'd42}) begin
            errors++;
            $display("FAIL write3: ack=%b err=%b busy=%b out=%0d, required 1 0 1 42", a, e, b, o);
        end
        checks++;
        if ({ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL write3_after: ack=%b busy=%b, required 0 0", ack, busy);
        end
        access(1'b1, 8'd4, 8'd7, o, a, e, b);
        access(1'b0, 8'd3, 8'd0, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b0, 8'd42}) begin
            errors++;
            $display("FAIL read3: ack=%b err=%b out=%0d, required 1 0 42", a, e, o);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] o; logic a, e, b;
        access(1'b1, 8'd8, 8'h77, o, a, e, b);
        access(1'b0, 8'd40, 8'd0, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL read40: ack=%b err=%b out=%h, required 1 1 00", a, e, o);
        end
        checks++;
        if ({ack, err} !== 2'b00) begin
            errors++;
            $display("FAIL read40_after: ack=%b err=%b, required 0 0", ack, err);
        end
        access(1'b1, 8'd40, 8'h11, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL write40: ack=%b err=%b out=%h, required 1 1 00", a, e, o);
        end
        access(1'b0, 8'd8, 8'd0, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b0, 8'h77}) begin
            errors++;
            $display("FAIL read8: ack=%b err=%b out=%h, required 1 0 77", a, e, o);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (out !== 8'h77) begin
            errors++;
            $display("FAIL out_hold: out=%h, required 77", out);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = 8'd3;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (ack === 1'b1) acks++;
            checks++;
            if (ack !== (i % 2 == 1) || busy !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ack=%b busy=%b, required %b %b", i, ack, busy, (i % 2 == 1), (i % 2 == 1));
            end
        end
        req = 1'b0;
        checks++;
        if (acks != 3) begin
            errors++;
            $display("FAIL b2b_count: acks=%0d, required 3", acks);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_ack();
        int late;
        late = 0;
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = 8'd40;
        @(negedge clock);
        req = 1'b0;
        checks++;
        if ({ack, err} !== 2'b11) begin
            errors++;
            $display("FAIL midack_pre: ack=%b err=%b, required 1 1", ack, err);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({ack, err, out} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL midack_reset: ack=%b err=%b out=%h, required 0 0 00", ack, err, out);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (ack !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL midack_noack: %0d late ack cycles, required 0", late);
        end
        wait_idle();
    endtask

    task automatic test_no_alias();
        logic [7:0] o; logic a, e, b;
        access(1'b1, 8'd0, 8'h5A, o, a, e, b);
        access(1'b1, 8'd31, 8'hFF, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL write31: ack=%b err=%b out=%h, required 1 0 ff", a, e, o);
        end
        access(1'b0, 8'd0, 8'd0, o, a, e, b);
        checks++;
        if ({a, e, o} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL read0: ack=%b err=%b out=%h, required 1 0 5a", a, e, o);
        end
        access(1'b0, 8'd31, 8'd0, o, a, e, b);
        checks++;
        if (o !== 8'hFF) begin
            errors++;
            $display("FAIL read31: out=%h, required ff", o);
        end
    endtask

    initial begin
        test_reset();
`ifdef RAM_INIT_CLEAR_EN
        test_clear();
`endif
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_ack();
        test_no_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
